// File: rtl/tt_um_axi4lite_top_core.sv
// ----------------------------------------------------------------------------
// tt_um_axi4lite_top_core
// Pin-level wrapper around an AXI4-Lite master FSM, an AXI4-Lite slave and a
// 4x8 register file. The master and slave talk only over internal AW/W/B/AR/R
// channels. Rising edges on the start pins launch one write or one read.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous reset, ACTIVE-HIGH (name kept for pin compat)
//   ena      in   unused
//   ui_in    in   [0] start_write, [2:1] write_addr, [3:2] read_addr,
//                 [4] start_read, [7:5] unused
//   uio_in   in   write data
//   uo_out   out  [0] done, [1] busy, [2] write_active, [3] read_active,
//                 [5:4] last response, [7:6] zero
//   uio_out  out  last read data
//   uio_oe   out  0xFF while the last read data is valid, else 0x00
//
// Configuration macro:
//   AXI4LITE_RESP_OUT_EN  when defined, uo_out[5:4] carries the last
//                         BRESP/RRESP; otherwise it is tied to 00.
// ----------------------------------------------------------------------------
module tt_um_axi4lite_top_core #(
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
   localparam logic [1:0]  RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WADDR,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_DONE
   } state_t;

   // Internal AXI4-Lite channels
   logic                  awvalid, awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid, wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  bvalid, bready;
   logic [1:0]            bresp;
   logic                  arvalid, arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid, rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   // Master-side state and registered outputs
   state_t                state;
   logic                  start_w_q, start_r_q;
   logic                  done_q, busy_q, wr_act_q, rd_act_q, read_valid_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Slave-side state
   logic                  aw_held, w_held;
   logic [ADDR_WIDTH-1:0] s_awaddr;
   logic [DATA_WIDTH-1:0] s_wdata;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic start_w_c, start_r_c;
   logic [1:0] resp;

   // Start edges: a level held high never retriggers
   assign start_w_c = ui_in[0] & ~start_w_q;
   assign start_r_c = ui_in[4] & ~start_r_q;

   assign bresp = RESP_OKAY;
   assign rresp = RESP_OKAY;

   // Master FSM; write wins when both starts coincide, starts while busy are dropped
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= S_IDLE;
         start_w_q    <= 1'b0;
         start_r_q    <= 1'b0;
         awvalid      <= 1'b0;
         awaddr       <= '0;
         wvalid       <= 1'b0;
         wdata        <= '0;
         bready       <= 1'b0;
         arvalid      <= 1'b0;
         araddr       <= '0;
         rready       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         wr_act_q     <= 1'b0;
         rd_act_q     <= 1'b0;
         read_valid_q <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         start_w_q <= ui_in[0];
         start_r_q <= ui_in[4];
         done_q    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_w_c) begin
                  awaddr       <= ADDR_WIDTH'(ui_in[2:1]);
                  wdata        <= DATA_WIDTH'(uio_in);
                  awvalid      <= 1'b1;
                  wvalid       <= 1'b1;
                  busy_q       <= 1'b1;
                  wr_act_q     <= 1'b1;
                  read_valid_q <= 1'b0;
                  state        <= S_WADDR;
               end else if (start_r_c) begin
                  araddr   <= ADDR_WIDTH'(ui_in[3:2]);
                  arvalid  <= 1'b1;
                  busy_q   <= 1'b1;
                  rd_act_q <= 1'b1;
                  state    <= S_RADDR;
               end
            end
            S_WADDR: begin
               // AW and W may finish in either order; leave once neither is pending
               if (awvalid && awready) awvalid <= 1'b0;
               if (wvalid && wready)   wvalid  <= 1'b0;
               if ((!awvalid || awready) && (!wvalid || wready)) begin
                  bready <= 1'b1;
                  state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (bvalid && bready) begin
                  bready   <= 1'b0;
                  wr_act_q <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_RADDR: begin
               if (arvalid && arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               // Read data lands on the same edge done rises
               if (rvalid && rready) begin
                  rready       <= 1'b0;
                  rd_act_q     <= 1'b0;
                  rd_data_q    <= rdata;
                  read_valid_q <= 1'b1;
                  done_q       <= 1'b1;
                  state        <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   // Slave: independent AW/W acceptance, register write once both beats are held
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         awready  <= 1'b0;
         wready   <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         s_awaddr <= '0;
         s_wdata  <= '0;
         bvalid   <= 1'b0;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rdata    <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      end else begin
         if (awvalid && awready) begin
            aw_held  <= 1'b1;
            s_awaddr <= awaddr;
            awready  <= 1'b0;
         end else if (awvalid && !aw_held && !awready) begin
            awready <= 1'b1;
         end

         if (wvalid && wready) begin
            w_held  <= 1'b1;
            s_wdata <= wdata;
            wready  <= 1'b0;
         end else if (wvalid && !w_held && !wready) begin
            wready <= 1'b1;
         end

         if (bvalid) begin
            if (bready) bvalid <= 1'b0;
         end else if (aw_held && w_held) begin
            regs[s_awaddr] <= s_wdata;
            bvalid         <= 1'b1;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
         end

         // RVALID follows the AR handshake by one cycle
         if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= regs[araddr];
         end else if (arvalid && !arready && !rvalid) begin
            arready <= 1'b1;
         end

         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

`ifdef AXI4LITE_RESP_OUT_EN
   // Last response seen on B or R
   logic [1:0] resp_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         resp_q <= 2'b00;
      end else if (bvalid && bready) begin
         resp_q <= bresp;
      end else if (rvalid && rready) begin
         resp_q <= rresp;
      end
   end

   assign resp = resp_q;
`else
   logic unused_resp;

   assign resp        = 2'b00;
   assign unused_resp = &{1'b0, bresp, rresp};
`endif

   logic unused_pins;
   assign unused_pins = &{1'b0, ena, ui_in[7:5]};

   assign uo_out  = {2'b00, resp, rd_act_q, wr_act_q, busy_q, done_q};
   assign uio_out = 8'(rd_data_q);
   assign uio_oe  = {8{read_valid_q}};

endmodule

// File: tb/tb_tt_um_axi4lite_top_core.sv
// ----------------------------------------------------------------------------
// Bench for tt_um_axi4lite_top_core: directed scenarios followed by random
// transactions, compared against a memory-array model of the register file.
// ----------------------------------------------------------------------------
module tb_tt_um_axi4lite_top_core;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [7:0] mem [4];
   logic [7:0] last_read;
   logic       rd_valid;

   tt_um_axi4lite_top_core dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      last_read = 8'h00;
      rd_valid  = 1'b0;
   endtask

   // One transaction: wr/rd select the start pins (both = coincident starts),
   // hold = cycles the start pin stays high, inject = raise start_read while busy.
   task automatic run_txn(input bit wr, input bit rd, input logic [1:0] addr,
                          input logic [7:0] data, input int hold, input bit inject);
      int         pulses;
      int         first_n;
      logic [7:0] u;
      pulses  = 0;
      first_n = 0;
      u = 8'h00;
      if (wr) begin
         u[0]   = 1'b1;
         u[2:1] = addr;
         if (rd) u[4] = 1'b1;
      end else begin
         u[4]   = 1'b1;
         u[3:2] = addr;
      end
      ui_in  = u;
      uio_in = data;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (n == 1) begin
            check("busy_after_start", 32'(uo_out[1]), 32'(1'b1));
            check("write_active", 32'(uo_out[2]), 32'(wr));
            check("read_active", 32'(uo_out[3]), 32'(!wr));
         end
         if (uo_out[0]) begin
            pulses++;
            if (pulses == 1) begin
               first_n = n;
               if (!wr) begin
                  check("read_data_at_done", 32'(uio_out), 32'(mem[addr]));
                  check("oe_at_done", 32'(uio_oe), 32'(8'hFF));
               end
            end
         end
         // Disturb captured fields; start pins follow hold/inject only
         u = 8'($urandom);
         u[0] = ui_in[0];
         u[4] = ui_in[4];
         if (n >= hold) begin
            u[0] = 1'b0;
            if (!inject) u[4] = 1'b0;
         end
         if (inject && n == 2) u[4] = 1'b1;
         ui_in  = u;
         uio_in = 8'($urandom);
      end
      check("done_pulse_count", 32'(pulses), 32'd1);
      check("done_within_8", 32'(first_n >= 2 && first_n <= 9), 32'd1);
      check("idle_after_txn", 32'(uo_out), 32'(8'h00));
      if (wr) begin
         mem[addr] = data;
         rd_valid  = 1'b0;
      end else begin
         last_read = mem[addr];
         rd_valid  = 1'b1;
      end
      check("uio_out_hold", 32'(uio_out), 32'(last_read));
      check("uio_oe_state", 32'(uio_oe), rd_valid ? 32'hFF : 32'h00);
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
   endtask

   initial begin
      logic       w;
      logic [1:0] a;
      logic [7:0] d;
      int         h;
      ena    = 1'b1;
      rst_n  = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      model_reset();
      repeat (3) tick();
      check("reset_uo_out", 32'(uo_out), 32'h00);
      check("reset_uio_out", 32'(uio_out), 32'h00);
      check("reset_uio_oe", 32'(uio_oe), 32'h00);
      rst_n = 1'b0;
      tick();

      // Read straight after reset
      run_txn(1'b0, 1'b0, 2'd1, 8'h00, 1, 1'b0);
      // Write 0x04 to addr 2 then read it back
      run_txn(1'b1, 1'b0, 2'd2, 8'h04, 1, 1'b0);
      run_txn(1'b0, 1'b0, 2'd2, 8'h00, 1, 1'b0);
      // Fill all four registers and read back
      run_txn(1'b1, 1'b0, 2'd0, 8'h11, 1, 1'b0);
      run_txn(1'b1, 1'b0, 2'd1, 8'h22, 1, 1'b0);
      run_txn(1'b1, 1'b0, 2'd2, 8'h33, 1, 1'b0);
      run_txn(1'b1, 1'b0, 2'd3, 8'h44, 1, 1'b0);
      for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b0, 2'(i), 8'h00, 1, 1'b0);
      // Coincident starts: write wins
      run_txn(1'b1, 1'b1, 2'd1, 8'hA5, 1, 1'b0);
      run_txn(1'b0, 1'b0, 2'd1, 8'h00, 1, 1'b0);
      // Read start while a write is busy is dropped
      run_txn(1'b1, 1'b0, 2'd0, 8'h6C, 1, 1'b1);
      run_txn(1'b0, 1'b0, 2'd0, 8'h00, 1, 1'b0);

      // Reset in the middle of a write response
      ui_in  = 8'b0000_0111;
      uio_in = 8'h5A;
      tick();
      ui_in = 8'h00;
      tick();
      tick();
      check("mid_write_active", 32'(uo_out[2:1]), 32'(2'b11));
      rst_n = 1'b1;
      #1;
      check("abort_uo_out", 32'(uo_out), 32'h00);
      check("abort_uio_out", 32'(uio_out), 32'h00);
      check("abort_uio_oe", 32'(uio_oe), 32'h00);
      tick();
      tick();
      check("abort_no_done", 32'(uo_out), 32'h00);
      rst_n = 1'b0;
      model_reset();
      tick();
      run_txn(1'b0, 1'b0, 2'd3, 8'h00, 1, 1'b0);
      run_txn(1'b0, 1'b0, 2'd0, 8'h00, 1, 1'b0);

      // Random traffic with random start hold times
      for (int k = 0; k < 40; k++) begin
         w = 1'($urandom_range(0, 1));
         a = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         h = int'($urandom_range(1, 14));
         run_txn(w, 1'b0, a, d, h, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tt_um_axi4lite_top_core.md
TT_UM_AXI4LITE_TOP_CORE -- requirements
Module: tt_um_axi4lite_top

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, register-file address width; only 2 is supported with this pinout.
REQ-002 Parameter DATA_WIDTH, default 8, register width; only 8 is supported with this pinout.
REQ-003 Reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-high reset; the suffix is kept for pin compatibility only, and 1 means reset.
REQ-006 ena  in  1  ignored by the design.
REQ-007 ui_in  in  8  bit0 start_write, bits[2:1] write_addr, bits[3:2] read_addr (bit2 shared), bit4 start_read, bits[7:5] unused.
REQ-008 uio_in  in  8  write data.
REQ-009 uo_out  out  8  bit0 done, bit1 busy, bit2 write_active, bit3 read_active, bits[5:4] last response, bits[7:6] 0.
REQ-010 uio_out  out  8  last read data.
REQ-011 uio_oe  out  8  0xFF while read_valid=1, else 0x00.

Function
REQ-012 The block shall contain an AXI4-Lite master FSM, an AXI4-Lite slave and a 4x8 register file, connected by internal AW/W/B/AR/R channels only.
REQ-013 Start detection shall be rising-edge based: a start is a 0->1 transition of ui_in[0] or ui_in[4] sampled at clk, and a held-high level shall not retrigger.
REQ-014 On the start edge, the address and data (write) or the address (read) shall be captured, and later ui_in/uio_in changes shall be ignored.
REQ-015 Master states shall be IDLE, WADDR (AWVALID=WVALID=1 until each handshakes), WRESP (BREADY=1 until BVALID), RADDR (ARVALID=1 until ARREADY), RDATA (RREADY=1 until RVALID) and DONE, then return to IDLE.
REQ-016 Each VALID shall be held stable until its READY is seen, and AW and W may complete in either order.
REQ-017 The slave shall assert AWREADY and WREADY independently, write the register only when both beats are held, then assert BVALID with BRESP=OKAY (00).
REQ-018 The slave shall answer AR with RVALID one cycle later, returning RDATA = reg[addr] and RRESP=OKAY.
REQ-019 done (uo_out[0]) shall be a single-cycle pulse in DONE, occurring no more than 8 cycles after the start edge.
REQ-020 For reads, uio_out shall be loaded on the same edge done rises, so the data is valid while done=1, and shall hold until the next read.
REQ-021 read_valid shall set with a read's done and clear on the next write start.
REQ-022 busy shall be 1 in any non-IDLE state, and starts arriving while busy shall be dropped.
REQ-023 If start_write and start_read edges coincide, the write shall be executed and the read dropped.

Reset
REQ-024 While rst_n=1, the FSM shall be forced to IDLE, all VALID/READY signals to 0, all registers, uio_out and read_valid to 0x00/0, and uo_out and uio_oe to 0x00.
REQ-025 A reset during a transaction shall abort it with no done pulse and no partial register write.

Configuration
REQ-026 Macro AXI4LITE_RESP_OUT_EN: when defined, uo_out[5:4] shall hold the last BRESP/RRESP; when undefined, uo_out[5:4] shall be tied to 00 and the response register omitted.

Verification
REQ-027 Reset, then pulse start_write for 1 cycle with write_addr=2 and uio_in=0x04 -> a single done pulse within 8 cycles.
REQ-028 Next, pulse start_read with read_addr=2 -> done pulse with uio_out=0x04 and uio_oe=0xFF while done=1.
REQ-029 Read addr 1 straight after reset -> uio_out=0x00.
REQ-030 Write 0x11/0x22/0x33/0x44 to addr 0-3, then read back all four -> the matching values, with no cross-address corruption.
REQ-031 Start a read while a write is busy -> the read is ignored with no second done pulse; assert rst_n=1 in WRESP -> outputs are 0 and the register is unchanged.
REQ-032 Raise both starts in the same cycle with addr=1 and data=0xA5 -> only the write completes, then a read of addr 1 returns 0xA5.
